// File: rtl/t05_hdecoder.sv
// Huffman tree walker: fetches node records from SRAM, steers left/right per
// compressed bit and emits one character per leaf reached.
module t05_hdecoder (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  en,
  input  logic [6:0]  root_idx,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        bit_last,
  output logic        bit_ready,
  output logic        rd_req,
  output logic [6:0]  rd_addr,
  input  logic [70:0] rd_data,
  input  logic        rd_done,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [15:0] char_count,
  output logic [1:0]  err_code,
  output logic [3:0]  op_fin
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAITBIT, S_EMIT, S_FIN, S_ERR
  } state_e;

  localparam logic [3:0] EN_GO      = 4'b0101;
  localparam logic [8:0] CHILD_NULL = 9'b110000000;

  state_e      state_q, state_d;
  logic [6:0]  cur_idx_q, cur_idx_d;
  logic [6:0]  depth_q, depth_d;
  logic [8:0]  left_q, left_d;
  logic [8:0]  right_q, right_d;
  logic        last_q, last_d;
  logic [7:0]  char_q, char_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  err_q, err_d;
  logic [8:0]  child;

  // The subtree weight field is only meaningful to the tree builder.
  logic unused_sum;
  assign unused_sum = ^rd_data[45:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      depth_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      last_q    <= 1'b0;
      char_q    <= '0;
      count_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      depth_q   <= depth_d;
      left_q    <= left_d;
      right_q   <= right_d;
      last_q    <= last_d;
      char_q    <= char_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    depth_d   = depth_q;
    left_d    = left_q;
    right_d   = right_q;
    last_d    = last_q;
    char_d    = char_q;
    count_d   = count_q;
    err_d     = err_q;
    child     = bit_in ? right_q : left_q;

    // Abort wins over any in-flight handshake; counters and error code persist.
    if (state_q != S_IDLE && en != EN_GO) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en == EN_GO) begin
            cur_idx_d = root_idx;
            depth_d   = '0;
            count_d   = '0;
            err_d     = '0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_done) begin
            left_d  = rd_data[63:55];
            right_d = rd_data[54:46];
            if (rd_data[70:64] != cur_idx_q) begin
              err_d   = 2'b10;
              state_d = S_ERR;
            end else if (depth_q == 7'd127) begin
              err_d   = 2'b11;
              state_d = S_ERR;
            end else begin
              depth_d = depth_q + 7'd1;
              state_d = S_WAITBIT;
            end
          end
        end
        S_WAITBIT: begin
          if (bit_valid) begin
            last_d = bit_last;
            if (child == CHILD_NULL) begin
              err_d   = 2'b01;
              state_d = S_ERR;
            end else if (child[8]) begin
              if (bit_last) begin
                err_d   = 2'b11;
                state_d = S_ERR;
              end else begin
                cur_idx_d = child[6:0];
                state_d   = S_FETCH;
              end
            end else begin
              char_d  = child[7:0];
              state_d = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            if (last_q) begin
              state_d = S_FIN;
            end else begin
              cur_idx_d = root_idx;
              depth_d   = '0;
              state_d   = S_FETCH;
            end
          end
        end
        S_FIN:   state_d = S_FIN;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd_req     = (state_q == S_FETCH);
  assign rd_addr    = cur_idx_q;
  assign bit_ready  = (state_q == S_WAITBIT);
  assign char_valid = (state_q == S_EMIT);
  assign char_out   = char_q;
  assign char_count = count_q;
  assign err_code   = err_q;

  always_comb begin
    op_fin = 4'b0000;
    if (state_q == S_FIN) op_fin = 4'b0011;
    if (state_q == S_ERR) op_fin = 4'b1000;
  end

endmodule

// File: tb/tb_t05_hdecoder.sv
// Scoreboard bench for t05_hdecoder: SRAM responder, random bit/char handshakes,
// and a tree-walking reference model that predicts characters and final status.
module tb_t05_hdecoder;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  en;
  logic [6:0]  root_idx;
  logic        bit_in, bit_valid, bit_last, bit_ready;
  logic        rd_req, rd_done;
  logic [6:0]  rd_addr;
  logic [70:0] rd_data;
  logic [7:0]  char_out;
  logic        char_valid, char_ready;
  logic [15:0] char_count;
  logic [1:0]  err_code;
  logic [3:0]  op_fin;

  always #5 clk = ~clk;

  t05_hdecoder dut (
    .clk(clk), .nrst(nrst), .en(en), .root_idx(root_idx),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last), .bit_ready(bit_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .char_count(char_count), .err_code(err_code), .op_fin(op_fin)
  );

  logic [70:0] mem [128];
  bit          bq[$];
  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          bp_hold = 1'b0;
  int          lat_fix = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] rec(input logic [6:0] idx, input logic [8:0] l, input logic [8:0] r);
    logic [63:0] s;
    s = {$urandom(), $urandom()};
    return {idx, l, r, s[45:0]};
  endfunction

  // SRAM: answers rd_req after a latency, and throws stray rd_done pulses otherwise.
  initial begin
    int cnt;
    logic [95:0] g;
    cnt = -1;
    rd_done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      g = {$urandom(), $urandom(), $urandom()};
      rd_done = 1'b0;
      rd_data = g[70:0];
      if (rd_req) begin
        if (cnt < 0) cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          rd_done = 1'b1;
          rd_data = mem[rd_addr];
          cnt = -1;
        end else cnt--;
      end else begin
        cnt = -1;
        rd_done = ($urandom() % 5 == 0);
      end
    end
  end

  // Monitor: randomises char_ready and checks each completed transfer.
  initial begin
    char_ready = 1'b0;
    forever begin
      @(negedge clk);
      char_ready = bp_hold ? 1'b0 : ($urandom() % 3 != 0);
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_char: got %0h expected none", char_out);
        end else chk("char_out", 32'(char_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // Reference: walk the tree in memory bit by bit, re-fetching the root per character.
  task automatic model(input logic [6:0] root, output logic [1:0] e_err,
                       output logic [3:0] e_fin, output int e_cnt);
    logic [6:0]  node;
    logic [70:0] r;
    logic [8:0]  c;
    int          fetches;
    bit          last;
    node = root; fetches = 0; e_err = 2'b00; e_fin = 4'b0000; e_cnt = 0;
    for (int i = 0; i < bq.size(); i++) begin
      r = mem[node];
      fetches++;
      if (r[70:64] != node) begin e_err = 2'b10; e_fin = 4'b1000; return; end
      if (fetches == 128)   begin e_err = 2'b11; e_fin = 4'b1000; return; end
      c = bq[i] ? r[54:46] : r[63:55];
      last = (i == bq.size() - 1);
      if (c == 9'h180) begin
        e_err = 2'b01; e_fin = 4'b1000; return;
      end else if (c[8]) begin
        if (last) begin e_err = 2'b11; e_fin = 4'b1000; return; end
        node = c[6:0];
      end else begin
        exp_q.push_back(c[7:0]);
        e_cnt++;
        if (last) begin e_fin = 4'b0011; return; end
        node = root;
        fetches = 0;
      end
    end
  endtask

  task automatic run(input logic [6:0] root);
    logic [1:0] e_err;
    logic [3:0] e_fin;
    int         e_cnt, i, guard, n;
    bit         rdy_s;
    model(root, e_err, e_fin, e_cnt);
    n = bq.size();
    @(negedge clk);
    root_idx = root; en = 4'b0101;
    i = 0; guard = 0; rdy_s = 1'b0; bit_valid = 1'b0;
    forever begin
      @(negedge clk);
      guard++;
      if (bit_valid && rdy_s) i++;
      bit_valid = 1'b0;
      if (i >= n || op_fin != 4'b0000 || guard > 3000) break;
      rdy_s     = bit_ready;
      bit_in    = bq[i];
      bit_last  = (i == n - 1);
      bit_valid = ($urandom() % 4 != 0);
    end
    guard = 0;
    while (op_fin == 4'b0000 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("op_fin", 32'(op_fin), 32'(e_fin));
    chk("err_code", 32'(err_code), 32'(e_err));
    chk("char_count", 32'(char_count), 32'(e_cnt));
    chk("pending_chars", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    en = 4'b0000;
    @(negedge clk);
    chk("idle_op_fin", 32'(op_fin), 32'd0);
    chk("kept_err", 32'(err_code), 32'(e_err));
    chk("kept_count", 32'(char_count), 32'(e_cnt));
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 128; k++) mem[k] = rec(7'(k), 9'h180, 9'h180);
  endtask

  task automatic tree1();
    mem[1] = rec(7'd1, 9'h041, 9'h100);
    mem[0] = rec(7'd0, 9'h042, 9'h043);
  endtask

  function automatic logic [8:0] rchild(input int k, input int nn, input int base);
    int p;
    p = int'($urandom() % 10);
    if (k < nn - 1 && p < 4) return {2'b10, 7'(base + int'($urandom_range(k + 1, nn - 1)))};
    if (p == 4) return 9'h180;
    return {1'b0, 8'($urandom())};
  endfunction

  task automatic rand_tree(output logic [6:0] root);
    int base, nn;
    base = int'($urandom_range(0, 100));
    nn   = int'($urandom_range(2, 12));
    for (int k = 0; k < nn; k++)
      mem[base + k] = rec(7'(base + k), rchild(k, nn, base), rchild(k, nn, base));
    if ($urandom() % 8 == 0) begin
      int k;
      k = base + int'($urandom_range(0, nn - 1));
      mem[k][64] = ~mem[k][64];
    end
    root = 7'(base);
  endtask

  task automatic gen_bits(input logic [6:0] root, input int target);
    logic [6:0] node;
    logic [8:0] c;
    int         chars;
    bit         b;
    bq.delete();
    node = root; chars = 0;
    while (bq.size() < 200) begin
      b = 1'($urandom());
      c = b ? mem[node][54:46] : mem[node][63:55];
      bq.push_back(b);
      if (c == 9'h180) break;
      if (c[8]) begin
        if ($urandom() % 25 == 0) break;
        node = c[6:0];
      end else begin
        chars++;
        if (chars == target) break;
        node = root;
      end
    end
  endtask

  task automatic bp_check();
    int   g;
    logic [7:0]  v;
    logic [15:0] c0;
    g = 0;
    while (!char_valid && g < 500) begin @(negedge clk); g++; end
    chk("bp_valid_seen", 32'(char_valid), 32'd1);
    v = char_out; c0 = char_count;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(char_valid), 32'd1);
      chk("bp_char_stable", 32'(char_out), 32'(v));
      chk("bp_bit_ready", 32'(bit_ready), 32'd0);
      chk("bp_rd_req", 32'(rd_req), 32'd0);
      chk("bp_count_hold", 32'(char_count), 32'(c0));
    end
    bp_hold = 1'b0;
    g = 0;
    while (char_valid && g < 100) begin @(negedge clk); g++; end
    chk("bp_count_once", 32'(char_count), 32'(c0 + 16'd1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_bit_ready"}, 32'(bit_ready), 32'd0);
    chk({tag, "_char_valid"}, 32'(char_valid), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_char_out"}, 32'(char_out), 32'd0);
    chk({tag, "_char_count"}, 32'(char_count), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_op_fin"}, 32'(op_fin), 32'd0);
  endtask

  initial begin
    logic [6:0] root;
    int g;
    nrst = 1'b0; en = 4'b0000; root_idx = '0;
    bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    clear_mem();
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Basic decode: A, B, C
    tree1();
    lat_fix = 2;
    bq = '{0, 1, 0, 1, 1};
    run(7'd1);
    lat_fix = -1;

    // Single-character tree, then its null right child
    mem[0] = rec(7'd0, 9'h05A, 9'h180);
    bq = '{0, 0, 0};
    run(7'd0);
    bq = '{1};
    run(7'd0);

    // Truncated mid-path, then index mismatch
    tree1();
    bq = '{1};
    run(7'd1);
    mem[1] = rec(7'd5, 9'h041, 9'h100);
    bq = '{0};
    run(7'd1);
    tree1();

    // Depth overrun: node 0 loops to itself on 0
    mem[0] = rec(7'd0, 9'h100, 9'h041);
    bq.delete();
    for (int k = 0; k < 130; k++) bq.push_back(1'b0);
    run(7'd0);

    // Backpressure on the first character
    tree1();
    bq = '{0, 1, 0, 1, 1};
    bp_hold = 1'b1;
    fork
      run(7'd1);
      bp_check();
    join

    // Abort mid-FETCH, check start latency, then a clean re-run
    lat_fix = 3;
    @(negedge clk);
    root_idx = 7'd1; en = 4'b0101;
    @(posedge clk); #1;
    chk("start_rd_req", 32'(rd_req), 32'd1);
    chk("start_rd_addr", 32'(rd_addr), 32'd1);
    @(negedge clk);
    en = 4'b0000;
    @(posedge clk); #1;
    chk("abort_rd_req", 32'(rd_req), 32'd0);
    chk("abort_op_fin", 32'(op_fin), 32'd0);
    lat_fix = -1;
    run(7'd1);

    // Asynchronous reset while a character is held in EMIT
    bp_hold = 1'b1;
    @(negedge clk);
    root_idx = 7'd1; en = 4'b0101;
    g = 0;
    while (!bit_ready && g < 50) begin @(negedge clk); g++; end
    bit_in = 1'b0; bit_last = 1'b0; bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    g = 0;
    while (!char_valid && g < 50) begin @(negedge clk); g++; end
    chk("pre_reset_char", 32'(char_out), 32'h41);
    #2 nrst = 1'b0;
    #1 chk_reset_vals("async");
    en = 4'b0000;
    bp_hold = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

    // Random trees and streams
    for (int t = 0; t < 25; t++) begin
      rand_tree(root);
      gen_bits(root, int'($urandom_range(1, 6)));
      run(root);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
